riscv_coredpathvecmemunit: RTL and testbench
============================================

// Module: riscv_CoreDpathVecMemUnit
//
// PURPOSE
// Vector load/store sequencer directly upstream of the vector register file write port.
// - Accepts one strided vector memory op per handshake.
// - Emits one 32-bit element request per lane (lane i = bits [32i+31:32i] of the 256-bit vector).
// - For loads: assembles the returned elements and drives the vector regfile write port.
// - For stores: drains the store vector, read from regfile port 1, to memory.
//
// PARAMETERS
// NLANES     8    elements per vector register (256/32); vl saturates at NLANES
// ELEM_W     32   element width in bits
//
// PORTS
// clk            in   1    clock; all state updates on rising edge
// reset          in   1    synchronous, active-high reset
// req_val        in   1    op valid
// req_rdy        out  1    unit can accept an op (high only in IDLE)
// req_st         in   1    0 = load, 1 = store
// req_base       in   32   byte address of element 0
// req_stride     in   32   byte stride between elements (two's complement)
// req_vd         in   5    load destination vector register
// req_vdata      in   256  store: data to write; load: current vd contents (tail-lane source)
// vl             in   4    active vector length, sampled on accept
// memreq_val     out  1    element request valid
// memreq_rdy     in   1    memory accepts request
// memreq_rw      out  1    0 = read, 1 = write
// memreq_addr    out  32   element byte address
// memreq_data    out  32   store element data
// memresp_val    in   1    response valid (loads: data; stores: write ack)
// memresp_data   in   32   load element data
// wen_p          out  1    regfile write enable (one-cycle pulse)
// waddr_p        out  5    regfile write address
// wdata_p        out  256  regfile write vector
// busy           out  1    op in flight (not IDLE)
//
// BEHAVIOUR
// - States: IDLE, REQ, RESP, WB.
// - Reset (from any state, mid-op included):
//   - state = IDLE; wen_p, memreq_val, busy = 0; req_rdy = 1.
//   - Element counter and assembled data = 0.
//   - An in-flight op is abandoned; no write occurs.
// - Accept: req_val && req_rdy in IDLE.
//   - Latch st, vd, vdata.
//   - Latch n = min(vl, NLANES); vl values 9..15 clamp to 8.
//   - Latch addr = req_base; idx = 0.
// - Transitions from IDLE on accept:
//   - n == 0 and load -> WB.
//   - n == 0 and store -> IDLE; no memory traffic.
//   - n > 0 -> REQ.
// - REQ:
//   - memreq_val = 1; memreq_addr = addr.
//   - memreq_data = vdata[32*idx +: 32].
//   - On memreq_rdy -> RESP.
// - RESP: wait for memresp_val; exactly one request is outstanding.
//   - Load: capture memresp_data into lane idx.
//   - Then idx++; addr = addr + stride (mod 2^32, wrap-around allowed).
//   - idx == n -> WB for a load, IDLE for a store; otherwise -> REQ.
// - WB (loads only): for one cycle wen_p = 1, waddr_p = vd, wdata_p = assembled vector; -> IDLE.
//   - vd == 0: pulse still issued; the regfile discards the write.
// - memresp_val outside RESP is ignored.
// - req_rdy is 0 in REQ/RESP/WB; a req_val held in WB is accepted in the following IDLE cycle.
// - Minimum latency: 2 cycles per element (zero-wait memory) plus 1 WB cycle.
// - wdata_p/waddr_p are don't-care when wen_p = 0; the bench must not check them then.
//
// CONFIGURATION
// RISCV_VECMEM_ZEROFILL_EN
//   - Defined: load tail lanes (idx >= n) are written as 0.
//   - Undefined: tail lanes take the latched req_vdata lanes, so old vd contents are preserved.
//   - Stores are identical either way; tail lanes never generate memory traffic.
//
// TESTING
// 1. Unit-stride load, vl=8, base=0x100, stride=4, vd=3, mem[a]=a:
//    -> reads 0x100..0x11C; one wen_p pulse; waddr_p=3; lane i = 0x100+4i.
// 2. Store, vl=3, base=0x200, stride=-8, vdata lanes = 0xA0..0xA7:
//    -> writes 0x200=0xA0, 0x1F8=0xA1, 0x1F0=0xA2; no wen_p; back to IDLE.
// 3. Load, vl=2, req_vdata = all 0xFFFFFFFF:
//    -> ZEROFILL_EN defined: lanes 2..7 = 0.
//    -> ZEROFILL_EN undefined: lanes 2..7 = 0xFFFFFFFF.
// 4. vl=0:
//    -> load: wen_p pulse within 2 cycles of accept, no memreq_val.
//    -> store: back in IDLE the next cycle.
//    vl=12: -> exactly 8 element requests.
// 5. Backpressure: memreq_rdy low 3 cycles, memresp_val delayed 5 cycles per element
//    -> memreq_addr/memreq_data stable while stalled; correct data; spurious memresp_val in IDLE ignored.
// 6. Assert reset in RESP of element 4:
//    -> next cycle IDLE, req_rdy=1, no wen_p.
//    -> A new load after reset completes correctly.

Source files
------------

// File: rtl/riscv_coredpathvecmemunit_if.sv
// Signal bundle around the vector memory unit: op issue handshake, the
// element-wide memory request/response port and the vector regfile write
// port. The slave modport is the unit itself; the master modport is its
// environment (op issuer, memory and regfile together).
interface riscv_coredpathvecmemunit_if #(
    parameter int NLANES = 8,
    parameter int ELEM_W = 32
);
    localparam int VEC_W = NLANES * ELEM_W;

    // op issue
    logic             req_val;
    logic             req_rdy;
    logic             req_st;
    logic [31:0]      req_base;
    logic [31:0]      req_stride;
    logic [4:0]       req_vd;
    logic [VEC_W-1:0] req_vdata;
    logic [3:0]       vl;

    // element memory port
    logic              memreq_val;
    logic              memreq_rdy;
    logic              memreq_rw;
    logic [31:0]       memreq_addr;
    logic [ELEM_W-1:0] memreq_data;
    logic              memresp_val;
    logic [ELEM_W-1:0] memresp_data;

    // regfile write port and status
    logic             wen_p;
    logic [4:0]       waddr_p;
    logic [VEC_W-1:0] wdata_p;
    logic             busy;

    modport master (
        output req_val, req_st, req_base, req_stride, req_vd, req_vdata, vl,
        output memreq_rdy, memresp_val, memresp_data,
        input  req_rdy, memreq_val, memreq_rw, memreq_addr, memreq_data,
        input  wen_p, waddr_p, wdata_p, busy
    );

    modport slave (
        input  req_val, req_st, req_base, req_stride, req_vd, req_vdata, vl,
        input  memreq_rdy, memresp_val, memresp_data,
        output req_rdy, memreq_val, memreq_rw, memreq_addr, memreq_data,
        output wen_p, waddr_p, wdata_p, busy
    );
endinterface

// File: rtl/riscv_coredpathvecmemunit.sv
// Vector load/store sequencer feeding the vector regfile write port.
// One strided op is accepted per handshake; it is split into one 32-bit
// element request per active lane with exactly one request outstanding.
// Loads assemble the returned lanes and write the whole vector back in a
// single WB cycle; stores drain the latched store vector to memory.
//
// Build option RISCV_VECMEM_ZEROFILL_EN:
//   defined   - load tail lanes (idx >= n) are written as zero
//   undefined - load tail lanes keep the latched req_vdata (old vd contents)
module riscv_coredpathvecmemunit #(
    parameter int NLANES = 8,
    parameter int ELEM_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    riscv_coredpathvecmemunit_if.slave  bus
);
    localparam int CNT_W  = $clog2(NLANES + 1);
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

    state_t            state_reg;
    logic              st_reg;
    logic [4:0]        vd_reg;
    logic [CNT_W-1:0]  n_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       stride_reg;

    logic              accept;
    logic              resp_fire;
    logic [CNT_W-1:0]  n_next;
    logic [CNT_W-1:0]  idx_next;
    logic [ELEM_W-1:0] vdata_lane [NLANES];

    assign accept    = (state_reg == IDLE) && bus.req_val;
    assign resp_fire = (state_reg == RESP) && bus.memresp_val;
    assign idx_next  = idx_reg + CNT_W'(1);
    // vl beyond the register length simply saturates to a full vector
    assign n_next    = (32'(bus.vl) > 32'(NLANES)) ? CNT_W'(NLANES) : CNT_W'(bus.vl);

    // Sequencer: op latch, element counter, address walk and state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            st_reg     <= 1'b0;
            vd_reg     <= '0;
            n_reg      <= '0;
            idx_reg    <= '0;
            addr_reg   <= '0;
            stride_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_val) begin
                        st_reg     <= bus.req_st;
                        vd_reg     <= bus.req_vd;
                        n_reg      <= n_next;
                        idx_reg    <= '0;
                        addr_reg   <= bus.req_base;
                        stride_reg <= bus.req_stride;
                        if (n_next != '0) begin
                            state_reg <= REQ;
                        end else if (bus.req_st) begin
                            // empty store: nothing to move, stay available
                            state_reg <= IDLE;
                        end else begin
                            // empty load still rewrites vd (tail rule applies)
                            state_reg <= WB;
                        end
                    end
                end
                REQ: begin
                    if (bus.memreq_rdy) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (bus.memresp_val) begin
                        idx_reg  <= idx_next;
                        addr_reg <= addr_reg + stride_reg;
                        if (idx_next != n_reg) begin
                            state_reg <= REQ;
                        end else if (st_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= WB;
                        end
                    end
                end
                WB: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [ELEM_W-1:0] vdata_reg;
            logic [ELEM_W-1:0] asm_reg;

            // Per-lane store source and load assembly; the assembly register is
            // preloaded with the tail value so lanes never returned keep it
            always_ff @(posedge clk) begin
                if (reset) begin
                    vdata_reg <= '0;
                    asm_reg   <= '0;
                end else if (accept) begin
                    vdata_reg <= bus.req_vdata[gi*ELEM_W +: ELEM_W];
`ifdef RISCV_VECMEM_ZEROFILL_EN
                    asm_reg   <= '0;
`else
                    asm_reg   <= bus.req_vdata[gi*ELEM_W +: ELEM_W];
`endif
                end else if (resp_fire && !st_reg && (idx_reg == CNT_W'(gi))) begin
                    asm_reg   <= bus.memresp_data;
                end
            end

            assign vdata_lane[gi]                    = vdata_reg;
            assign bus.wdata_p[gi*ELEM_W +: ELEM_W]  = asm_reg;
        end
    endgenerate

    // Outputs decode straight from registered state, so they are glitch-free
    // and hold steady for as long as memory stalls the request
    assign bus.req_rdy     = (state_reg == IDLE);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.memreq_val  = (state_reg == REQ);
    assign bus.memreq_rw   = st_reg;
    assign bus.memreq_addr = addr_reg;
    assign bus.memreq_data = vdata_lane[idx_reg[LANE_W-1:0]];
    assign bus.wen_p       = (state_reg == WB);
    assign bus.waddr_p     = vd_reg;
endmodule

// File: tb/tb_riscv_coredpathvecmemunit.sv
// Self-checking bench for the vector memory unit: a reactive memory model
// with programmable request backpressure, response delay and stray
// responses, plus a per-op reference computed from the op description.
module tb_riscv_coredpathvecmemunit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    riscv_coredpathvecmemunit_if #(.NLANES(8), .ELEM_W(32)) bus ();
    riscv_coredpathvecmemunit #(.NLANES(8), .ELEM_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { logic [4:0] a; logic [255:0] d; int c; } wb_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    req_t req_log[$];
    req_t exp_req[$];
    wb_t  wb_log[$];
    bit           exp_wen;
    logic [4:0]   exp_waddr;
    logic [255:0] exp_wdata;
    logic [31:0]  mem [logic [31:0]];
    int rdy_delay = 0;
    int resp_delay = 0;
    bit spur_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Reference: n = min(vl,8) element accesses at base + i*stride; loads write
    // vd once with fetched lanes below n and the tail rule above.
    task automatic build_expect(input bit st, input logic [31:0] base, input logic [31:0] stride,
                                input logic [4:0] vd, input logic [255:0] vdata, input logic [3:0] vl);
        int n;
        req_t r;
        n = (vl > 4'd8) ? 8 : int'(vl);
        exp_req.delete();
        exp_wen = !st;
        exp_waddr = vd;
`ifdef RISCV_VECMEM_ZEROFILL_EN
        exp_wdata = '0;
`else
        exp_wdata = vdata;
`endif
        for (int i = 0; i < n; i++) begin
            r.rw = st;
            r.addr = base + 32'(i) * stride;
            r.data = vdata[32*i +: 32];
            exp_req.push_back(r);
            if (!st) exp_wdata[32*i +: 32] = mem_rd(r.addr);
        end
    endtask

    // -1 when the observed request sequence equals the reference, else the
    // first differing index (1000+size on a length difference)
    function automatic int first_req_diff();
        if (req_log.size() != exp_req.size()) return 1000 + req_log.size();
        foreach (exp_req[i]) begin
            if (req_log[i].rw !== exp_req[i].rw || req_log[i].addr !== exp_req[i].addr ||
                (exp_req[i].rw && req_log[i].data !== exp_req[i].data))
                return i;
        end
        return -1;
    endfunction

    // Memory model and write-port monitor, all on the falling edge
    initial begin : mem_model
        int stall_cnt;
        int wait_cnt;
        bit pend;
        bit stalled;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic [31:0] resp_d;
        stall_cnt = 0; wait_cnt = 0; pend = 0; stalled = 0; resp_d = '0;
        st_addr = '0; st_data = '0;
        bus.memreq_rdy = 1'b0;
        bus.memresp_val = 1'b0;
        bus.memresp_data = '0;
        forever begin
            @(negedge clk);
            if (bus.wen_p === 1'b1) wb_log.push_back(wb_t'{bus.waddr_p, bus.wdata_p, cyc});
            bus.memresp_val = 1'b0;
            if (reset) begin
                pend = 0; stalled = 0; stall_cnt = 0;
                bus.memreq_rdy = 1'b0;
            end else begin
                if (stalled) begin
                    vectors++;
                    if (bus.memreq_val !== 1'b1 || bus.memreq_addr !== st_addr || bus.memreq_data !== st_data) begin
                        miscompares++;
                        $display("FAIL stall_hold: val=%b addr=%h data=%h, required val=1 addr=%h data=%h",
                                 bus.memreq_val, bus.memreq_addr, bus.memreq_data, st_addr, st_data);
                    end
                    stalled = 0;
                end
                if (pend) begin
                    if (wait_cnt == 0) begin
                        bus.memresp_val = 1'b1;
                        bus.memresp_data = resp_d;
                        pend = 0;
                    end else begin
                        wait_cnt--;
                    end
                end else if (spur_en && bus.busy === 1'b0 && $urandom_range(0, 1) == 1) begin
                    bus.memresp_val = 1'b1;
                    bus.memresp_data = $urandom;
                end
                bus.memreq_rdy = 1'b0;
                if (bus.memreq_val === 1'b1) begin
                    if (stall_cnt < rdy_delay) begin
                        stall_cnt++;
                        stalled = 1;
                        st_addr = bus.memreq_addr;
                        st_data = bus.memreq_data;
                    end else begin
                        bus.memreq_rdy = 1'b1;
                        stall_cnt = 0;
                        req_log.push_back(req_t'{bus.memreq_rw, bus.memreq_addr, bus.memreq_data});
                        if (bus.memreq_rw) begin
                            mem[bus.memreq_addr] = bus.memreq_data;
                            resp_d = $urandom;
                        end else begin
                            resp_d = mem_rd(bus.memreq_addr);
                        end
                        pend = 1;
                        wait_cnt = resp_delay;
                    end
                end
            end
        end
    end

    task automatic drive_req(input bit st, input logic [31:0] base, input logic [31:0] stride,
                             input logic [4:0] vd, input logic [255:0] vdata, input logic [3:0] vl);
        bus.req_val = 1'b1;
        bus.req_st = st;
        bus.req_base = base;
        bus.req_stride = stride;
        bus.req_vd = vd;
        bus.req_vdata = vdata;
        bus.vl = vl;
        $display("txn st=%0d base=%h stride=%h vd=%0d vl=%0d", st, base, stride, vd, vl);
    endtask

    // Present one op and return the posedge count at which it was taken;
    // the op fields are scrambled afterwards so only latched values matter
    task automatic issue(input bit st, input logic [31:0] base, input logic [31:0] stride,
                         input logic [4:0] vd, input logic [255:0] vdata, input logic [3:0] vl,
                         output int acc);
        int t;
        t = 0;
        @(negedge clk);
        drive_req(st, base, stride, vd, vdata, vl);
        while (bus.req_rdy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.req_rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_rdy=%b after %0d cycles, required 1", bus.req_rdy, t);
        end
        acc = cyc + 1;
        @(negedge clk);
        bus.req_val = 1'b0;
        bus.req_st = $urandom_range(0, 1);
        bus.req_base = $urandom;
        bus.req_stride = $urandom;
        bus.req_vd = 5'($urandom);
        bus.req_vdata = rand_vec();
        bus.vl = 4'($urandom);
    endtask

    task automatic wait_idle(output int done);
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, t);
        end
        done = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.req_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b need 1", bus.req_rdy); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
        vectors++; if (bus.wen_p !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b need 0", bus.wen_p); end
        vectors++; if (bus.memreq_val !== 1'b0) begin miscompares++; $display("FAIL reset_memreq: got %b need 0", bus.memreq_val); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unit_load();
        logic [255:0] old;
        int acc, done, d;
        rdy_delay = 0; resp_delay = 0; spur_en = 0;
        old = rand_vec();
        build_expect(1'b0, 32'h100, 32'd4, 5'd3, old, 4'd8);
        req_log.delete(); wb_log.delete();
        issue(1'b0, 32'h100, 32'd4, 5'd3, old, 4'd8, acc);
        wait_idle(done);
        d = first_req_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL unit_load_reqs: bad index %0d got %0d reqs need %0d", d, req_log.size(), exp_req.size()); end
        vectors++;
        if (wb_log.size() != 1) begin
            miscompares++; $display("FAIL unit_load_wen: got %0d pulses need 1", wb_log.size());
        end else begin
            vectors++; if (wb_log[0].a !== 5'd3) begin miscompares++; $display("FAIL unit_load_waddr: got %0d need 3", wb_log[0].a); end
            vectors++; if (wb_log[0].d !== exp_wdata) begin miscompares++; $display("FAIL unit_load_wdata: got %h need %h", wb_log[0].d, exp_wdata); end
            vectors++; if (wb_log[0].d[255:224] !== 32'h11C) begin miscompares++; $display("FAIL unit_load_lane7: got %h need 0000011c", wb_log[0].d[255:224]); end
        end
        vectors++; if (done - acc != 17) begin miscompares++; $display("FAIL unit_load_latency: got %0d cycles need 17", done - acc); end
    endtask

    task automatic test_neg_store();
        logic [255:0] v;
        int acc, done, d;
        rdy_delay = 0; resp_delay = 0; spur_en = 0;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = 32'hA0 + 32'(i);
        build_expect(1'b1, 32'h200, 32'hFFFF_FFF8, 5'd9, v, 4'd3);
        req_log.delete(); wb_log.delete();
        issue(1'b1, 32'h200, 32'hFFFF_FFF8, 5'd9, v, 4'd3, acc);
        wait_idle(done);
        d = first_req_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL neg_store_reqs: bad index %0d got %0d reqs need %0d", d, req_log.size(), exp_req.size()); end
        vectors++; if (mem_rd(32'h1F0) !== 32'hA2) begin miscompares++; $display("FAIL neg_store_mem: got %h at 1f0 need 000000a2", mem_rd(32'h1F0)); end
        vectors++; if (wb_log.size() != 0) begin miscompares++; $display("FAIL neg_store_wen: got %0d pulses need 0", wb_log.size()); end
        vectors++; if (done - acc != 6) begin miscompares++; $display("FAIL neg_store_latency: got %0d cycles need 6", done - acc); end
    endtask

    task automatic test_tail();
        logic [255:0] ones;
        logic [191:0] tail_exp;
        logic [31:0] base;
        int acc, done;
        rdy_delay = 1; resp_delay = 1; spur_en = 0;
        ones = '1;
        base = {$urandom} & 32'hFFFF_FFFC;
`ifdef RISCV_VECMEM_ZEROFILL_EN
        tail_exp = '0;
`else
        tail_exp = '1;
`endif
        build_expect(1'b0, base, 32'd4, 5'd7, ones, 4'd2);
        req_log.delete(); wb_log.delete();
        issue(1'b0, base, 32'd4, 5'd7, ones, 4'd2, acc);
        wait_idle(done);
        vectors++; if (req_log.size() != 2) begin miscompares++; $display("FAIL tail_reqs: got %0d need 2", req_log.size()); end
        vectors++;
        if (wb_log.size() != 1) begin
            miscompares++; $display("FAIL tail_wen: got %0d pulses need 1", wb_log.size());
        end else begin
            vectors++; if (wb_log[0].d !== exp_wdata) begin miscompares++; $display("FAIL tail_wdata: got %h need %h", wb_log[0].d, exp_wdata); end
            vectors++; if (wb_log[0].d[255:64] !== tail_exp) begin miscompares++; $display("FAIL tail_lanes: got %h need %h", wb_log[0].d[255:64], tail_exp); end
        end
    endtask

    task automatic test_vl_zero();
        logic [255:0] v;
        int acc, done, d;
        rdy_delay = 0; resp_delay = 0; spur_en = 0;
        v = rand_vec();
        build_expect(1'b0, 32'h300, 32'd4, 5'd12, v, 4'd0);
        req_log.delete(); wb_log.delete();
        issue(1'b0, 32'h300, 32'd4, 5'd12, v, 4'd0, acc);
        wait_idle(done);
        vectors++; if (req_log.size() != 0) begin miscompares++; $display("FAIL vl0_load_reqs: got %0d need 0", req_log.size()); end
        vectors++;
        if (wb_log.size() != 1) begin
            miscompares++; $display("FAIL vl0_load_wen: got %0d pulses need 1", wb_log.size());
        end else begin
            vectors++; if (wb_log[0].c - acc > 2) begin miscompares++; $display("FAIL vl0_load_delay: got %0d cycles need <=2", wb_log[0].c - acc); end
            vectors++; if (wb_log[0].d !== exp_wdata) begin miscompares++; $display("FAIL vl0_load_wdata: got %h need %h", wb_log[0].d, exp_wdata); end
        end
        req_log.delete(); wb_log.delete();
        issue(1'b1, 32'h300, 32'd4, 5'd12, v, 4'd0, acc);
        vectors++; if (bus.busy !== 1'b0 || bus.req_rdy !== 1'b1) begin miscompares++; $display("FAIL vl0_store_idle: busy=%b rdy=%b need 0/1", bus.busy, bus.req_rdy); end
        repeat (3) @(negedge clk);
        vectors++; if (req_log.size() != 0 || wb_log.size() != 0) begin miscompares++; $display("FAIL vl0_store_traffic: got %0d reqs %0d wen need 0/0", req_log.size(), wb_log.size()); end
        v = rand_vec();
        build_expect(1'b0, 32'h800, 32'd12, 5'd1, v, 4'd12);
        req_log.delete(); wb_log.delete();
        issue(1'b0, 32'h800, 32'd12, 5'd1, v, 4'd12, acc);
        wait_idle(done);
        d = first_req_diff();
        vectors++; if (req_log.size() != 8) begin miscompares++; $display("FAIL vl12_count: got %0d reqs need 8", req_log.size()); end
        vectors++; if (d != -1) begin miscompares++; $display("FAIL vl12_reqs: bad index %0d", d); end
        vectors++; if (wb_log.size() != 1 || wb_log[0].d !== exp_wdata) begin miscompares++; $display("FAIL vl12_wdata: got %0d pulses, data %h need %h", wb_log.size(), wb_log[0].d, exp_wdata); end
    endtask

    task automatic test_stream(input string name, input int nops, input int rd, input int rsp, input bit spur);
        bit st;
        logic [31:0] base, stride;
        logic [4:0] vd;
        logic [255:0] v;
        logic [3:0] vl;
        int acc, done, d;
        spur_en = spur;
        for (int k = 0; k < nops; k++) begin
            rdy_delay = (rd < 0) ? $urandom_range(0, 3) : rd;
            resp_delay = (rsp < 0) ? $urandom_range(0, 4) : rsp;
            st = $urandom_range(0, 1);
            base = $urandom;
            case ($urandom_range(0, 3))
                0: stride = 32'd4;
                1: stride = 32'hFFFF_FFFC;
                2: stride = 32'($urandom_range(0, 16)) << 2;
                default: stride = $urandom;
            endcase
            vd = 5'($urandom);
            v = rand_vec();
            vl = 4'($urandom);
            build_expect(st, base, stride, vd, v, vl);
            req_log.delete(); wb_log.delete();
            issue(st, base, stride, vd, v, vl, acc);
            wait_idle(done);
            d = first_req_diff();
            vectors++; if (d != -1) begin miscompares++; $display("FAIL %s_reqs op %0d: bad index %0d got %0d reqs need %0d", name, k, d, req_log.size(), exp_req.size()); end
            vectors++;
            if (wb_log.size() != (exp_wen ? 1 : 0)) begin
                miscompares++; $display("FAIL %s_wen op %0d: got %0d pulses need %0d", name, k, wb_log.size(), exp_wen);
            end else if (exp_wen) begin
                vectors++; if (wb_log[0].a !== exp_waddr) begin miscompares++; $display("FAIL %s_waddr op %0d: got %0d need %0d", name, k, wb_log[0].a, exp_waddr); end
                vectors++; if (wb_log[0].d !== exp_wdata) begin miscompares++; $display("FAIL %s_wdata op %0d: got %h need %h", name, k, wb_log[0].d, exp_wdata); end
            end
        end
        spur_en = 0;
    endtask

    task automatic test_reset_midop();
        logic [255:0] v;
        logic [3:0] vl;
        int acc, done, d, t;
        rdy_delay = 0; resp_delay = 3; spur_en = 0;
        req_log.delete(); wb_log.delete();
        issue(1'b0, 32'h400, 32'd4, 5'd4, rand_vec(), 4'd8, acc);
        t = 0;
        while (req_log.size() < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req_rdy !== 1'b1) begin miscompares++; $display("FAIL midreset_rdy: got %b need 1", bus.req_rdy); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b need 0", bus.busy); end
        vectors++; if (bus.memreq_val !== 1'b0) begin miscompares++; $display("FAIL midreset_memreq: got %b need 0", bus.memreq_val); end
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if (wb_log.size() != 0) begin miscompares++; $display("FAIL midreset_wen: got %0d pulses need 0", wb_log.size()); end
        resp_delay = 0;
        v = rand_vec();
        vl = 4'($urandom_range(1, 8));
        build_expect(1'b0, 32'h500, 32'd8, 5'd21, v, vl);
        req_log.delete(); wb_log.delete();
        issue(1'b0, 32'h500, 32'd8, 5'd21, v, vl, acc);
        wait_idle(done);
        d = first_req_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL postreset_reqs: bad index %0d", d); end
        vectors++; if (wb_log.size() != 1 || wb_log[0].d !== exp_wdata || wb_log[0].a !== 5'd21) begin miscompares++; $display("FAIL postreset_wb: got %0d pulses addr %0d data %h need 1/21/%h", wb_log.size(), wb_log[0].a, wb_log[0].d, exp_wdata); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] v1, v2, e1, e2;
        int a1, a2, t, done;
        rdy_delay = 0; resp_delay = 0; spur_en = 0;
        v1 = rand_vec(); v2 = rand_vec();
        build_expect(1'b0, 32'h600, 32'd4, 5'd5, v1, 4'd1);
        e1 = exp_wdata;
        build_expect(1'b0, 32'h700, 32'd4, 5'd6, v2, 4'd2);
        e2 = exp_wdata;
        req_log.delete(); wb_log.delete();
        @(negedge clk);
        drive_req(1'b0, 32'h600, 32'd4, 5'd5, v1, 4'd1);
        a1 = cyc + 1;
        @(negedge clk);
        drive_req(1'b0, 32'h700, 32'd4, 5'd6, v2, 4'd2);
        t = 0;
        while (bus.req_rdy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        a2 = cyc + 1;
        @(negedge clk);
        bus.req_val = 1'b0;
        wait_idle(done);
        vectors++; if (a2 - a1 != 4) begin miscompares++; $display("FAIL b2b_accept_gap: got %0d cycles need 4", a2 - a1); end
        vectors++;
        if (wb_log.size() != 2) begin
            miscompares++; $display("FAIL b2b_wen: got %0d pulses need 2", wb_log.size());
        end else begin
            vectors++; if (wb_log[0].a !== 5'd5 || wb_log[0].d !== e1) begin miscompares++; $display("FAIL b2b_first: got %0d/%h need 5/%h", wb_log[0].a, wb_log[0].d, e1); end
            vectors++; if (wb_log[1].a !== 5'd6 || wb_log[1].d !== e2) begin miscompares++; $display("FAIL b2b_second: got %0d/%h need 6/%h", wb_log[1].a, wb_log[1].d, e2); end
        end
    endtask

    initial begin
        bus.req_val = 1'b0;
        bus.req_st = 1'b0;
        bus.req_base = '0;
        bus.req_stride = '0;
        bus.req_vd = '0;
        bus.req_vdata = '0;
        bus.vl = '0;
        test_reset();
        test_unit_load();
        test_neg_store();
        test_tail();
        test_vl_zero();
        test_stream("backpressure", 6, 3, 5, 1'b1);
        test_stream("random", 40, -1, -1, 1'b1);
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
        $fatal(1, "watchdog");
    end
endmodule
